// File: rtl/spi_ctrl.sv
// SPI host controller with TX/RX byte FIFOs, runtime CPOL/CPHA/bit order/SCK divider and software chip selects.
// Bus reads answer one cycle after request; TX pushes into a full FIFO are dropped and flagged.

module spi_ctrl_fifo #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_push,
  input  logic [Width-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [Width-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(Depth+1)-1:0]   o_cnt
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module spi_ctrl #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned DefaultDiv     = 1,
  parameter int unsigned TxDepth        = 64,
  parameter int unsigned RxDepth        = 64,
  parameter int unsigned NumCS          = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned RegAddr        = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic                 spi_rx_i,
  output logic                 spi_tx_o,
  output logic                 sck_o,
  output logic [NumCS-1:0]     cs_no,
  output logic                 irq_o
);
  localparam logic [RegAddr-1:0] AddrTx     = RegAddr'(32'h00);
  localparam logic [RegAddr-1:0] AddrRx     = RegAddr'(32'h04);
  localparam logic [RegAddr-1:0] AddrStatus = RegAddr'(32'h08);
  localparam logic [RegAddr-1:0] AddrCfg    = RegAddr'(32'h0C);
  localparam logic [RegAddr-1:0] AddrCs     = RegAddr'(32'h10);
  localparam logic [RegAddr-1:0] AddrIntr   = RegAddr'(32'h14);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;

  localparam int unsigned TxCntW = $clog2(TxDepth + 1);
  localparam int unsigned RxCntW = $clog2(RxDepth + 1);

  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic [15:0]          r_div;
  logic                 r_cpol;
  logic                 r_cpha;
  logic                 r_msb;
  logic                 r_rx_en;
  logic [NumCS-1:0]     r_cs;
  logic [2:0]           r_int_en;
  logic                 r_tx_ovf;
  logic                 r_rx_ovf;
  logic                 r_irq;
  logic [1:0]           r_state;
  logic [15:0]          r_div_cnt;
  logic [3:0]           r_edge_cnt;
  logic [7:0]           r_shift;
  logic [7:0]           r_rx_shift;
  logic                 r_tx;
  logic                 r_sck;
  logic                 r_rx_push;

  logic [RegAddr-1:0]   w_addr;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_tx_push;
  logic                 w_tx_pop;
  logic                 w_rx_pop;
  logic                 w_busy;
  logic [7:0]           w_tx_dat;
  logic [7:0]           w_rx_dat;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic [TxCntW-1:0]    w_tx_cnt;
  logic [RxCntW-1:0]    w_rx_cnt;
  logic [31:0]          w_tx_cnt32;
  logic [7:0]           w_tx_depth;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_tick;
  logic                 w_lead;
  logic                 w_sample;
  logic                 w_shift;
  logic                 w_unused;

  assign w_addr     = device_addr_i[RegAddr-1:0];
  assign w_wr       = device_req_i && device_we_i;
  assign w_rd       = device_req_i && !device_we_i;
  assign w_tx_push  = w_wr && (w_addr == AddrTx) && device_be_i[0];
  assign w_rx_pop   = w_rd && (w_addr == AddrRx) && !w_rx_empty;
  assign w_tx_pop   = (r_state == StIdle) && !w_tx_empty;
  assign w_busy     = (r_state != StIdle) || !w_tx_empty;
  assign w_tx_cnt32 = 32'(w_tx_cnt);
  assign w_tx_depth = (w_tx_cnt32 > 32'd255) ? 8'hFF : w_tx_cnt32[7:0];

  spi_ctrl_fifo #(.Depth(TxDepth), .Width(8)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_tx_push),
    .i_wdata (device_wdata_i[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_dat),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_cnt   (w_tx_cnt)
  );

  spi_ctrl_fifo #(.Depth(RxDepth), .Width(8)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (r_rx_push),
    .i_wdata (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_dat),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_cnt   (w_rx_cnt)
  );

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_addr)
        AddrRx:     if (!w_rx_empty) w_rdata[8:0] = {1'b1, w_rx_dat};
        AddrStatus: begin
          w_rdata[6:0]   = {r_rx_ovf, r_tx_ovf, w_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
          w_rdata[23:16] = w_tx_depth;
        end
        AddrCfg:    w_rdata[19:0] = {r_rx_en, r_msb, r_cpha, r_cpol, r_div};
        AddrCs:     w_rdata[NumCS-1:0] = r_cs;
        AddrIntr:   w_rdata[2:0] = r_int_en;
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_div    <= DefaultDiv[15:0];
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_msb    <= 1'b1;
      r_rx_en  <= 1'b1;
      r_cs     <= '1;
      r_int_en <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= device_req_i;
      r_rdata  <= w_rdata;
      if (w_wr && (w_addr == AddrCfg) && !w_busy) begin
        r_div   <= device_wdata_i[15:0];
        r_cpol  <= device_wdata_i[16];
        r_cpha  <= device_wdata_i[17];
        r_msb   <= device_wdata_i[18];
        r_rx_en <= device_wdata_i[19];
      end
      if (w_wr && (w_addr == AddrCs)) r_cs <= device_wdata_i[NumCS-1:0];
      if (w_wr && (w_addr == AddrIntr)) begin
        r_int_en <= device_wdata_i[2:0];
        if (device_wdata_i[8]) begin
          r_tx_ovf <= 1'b0;
          r_rx_ovf <= 1'b0;
        end
      end
      // A new overflow in the same cycle as a clear wins, so no event is lost.
      if (w_tx_push && w_tx_full) r_tx_ovf <= 1'b1;
      if (r_rx_push && w_rx_full) r_rx_ovf <= 1'b1;
      r_irq <= (r_int_en[0] && w_tx_empty && (r_state == StIdle)) ||
               (r_int_en[1] && !w_rx_empty) ||
               (r_int_en[2] && (r_tx_ovf || r_rx_ovf));
    end
  end

  // Edge numbering is 1-based: odd edges (even r_edge_cnt) are leading edges.
  assign w_tick   = (r_div_cnt == r_div);
  assign w_lead   = ~r_edge_cnt[0];
  assign w_sample = r_cpha ? ~w_lead : w_lead;
  assign w_shift  = r_cpha ? (w_lead && (r_edge_cnt != 4'd0)) : (~w_lead && (r_edge_cnt != 4'd15));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_tx       <= 1'b0;
      r_sck      <= 1'b0;
      r_rx_push  <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_state)
        StIdle: begin
          r_sck <= r_cpol;
          if (!w_tx_empty) begin
            r_shift <= w_tx_dat;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_tx       <= r_msb ? r_shift[7] : r_shift[0];
          r_edge_cnt <= '0;
          r_div_cnt  <= '0;
          r_state    <= StShift;
        end
        StShift: begin
          if (w_tick) begin
            r_div_cnt  <= '0;
            r_sck      <= ~r_sck;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (w_sample) begin
              r_rx_shift <= r_msb ? {r_rx_shift[6:0], spi_rx_i} : {spi_rx_i, r_rx_shift[7:1]};
            end
            if (w_shift) begin
              r_shift <= r_msb ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
              r_tx    <= r_msb ? r_shift[6] : r_shift[1];
            end
            if (r_edge_cnt == 4'd15) begin
              r_rx_push <= r_rx_en;
              r_state   <= StIdle;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign device_rvalid_o = r_rvalid;
  assign device_rdata_o  = r_rdata;
  assign spi_tx_o        = r_tx;
  assign sck_o           = r_sck;
  assign cs_no           = r_cs;
  assign irq_o           = r_irq;

  assign w_unused = ^{device_addr_i[AddrWidth-1:RegAddr], device_be_i[3:1],
                      device_wdata_i[DataWidth-1:20], w_rx_cnt, (ClockFrequency != 0)};
endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl: MISO looped to MOSI, an SCK/MOSI monitor checks transmitted bytes
// against a TX scoreboard queue and RXDATA reads are checked against an RX scoreboard queue.
module tb_spi_ctrl;
  localparam int TxD = 32;
  localparam int RxD = 16;
  localparam logic [11:0] A_TX = 12'h000, A_RX = 12'h004, A_ST = 12'h008,
                          A_CFG = 12'h00C, A_CS = 12'h010, A_INT = 12'h014;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        rvalid, mosi, miso, sck, irq;
  logic [3:0]  cs_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_msb = 1'b1, mon_en = 1'b0;
  logic       prev_sck;
  int         bitc, tx_seen, rises, first_rise, last_rise;
  logic [7:0] mbyte, mexp;

  always #5 clk = ~clk;
  assign miso = mosi;

  spi_ctrl #(.TxDepth(TxD), .RxDepth(RxD), .NumCS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid), .device_rdata_o(rdata), .spi_rx_i(miso),
    .spi_tx_o(mosi), .sck_o(sck), .cs_no(cs_n), .irq_o(irq));

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI line monitor: samples MOSI on the slave sampling edge of the current mode.
  initial begin
    prev_sck = 1'b0; bitc = 0; mbyte = '0; tx_seen = 0; rises = 0; first_rise = 0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitc = 0;
      end else if (mon_en && (sck !== prev_sck)) begin
        if (sck === 1'b1) begin
          rises++;
          if (rises == 1) first_rise = cyc;
          last_rise = cyc;
        end
        if ((sck != m_cpol) != m_cpha) begin
          mbyte = m_msb ? {mbyte[6:0], mosi} : {mosi, mbyte[7:1]};
          bitc++;
          if (bitc == 8) begin
            bitc = 0;
            tx_seen++;
            n_tests++;
            if (tx_q.size() == 0) begin
              n_fail++;
              $display("FAIL mosi_byte: got %02h, none expected", mbyte);
            end else begin
              mexp = tx_q.pop_front();
              if (mbyte !== mexp) begin
                n_fail++;
                $display("FAIL mosi_byte: got %02h want %02h", mbyte, mexp);
              end
            end
          end
        end
      end
      prev_sck = sck;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_xfer(input logic w, input logic [11:0] a, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = {20'b0, a}; wdata = d; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    r = rdata;
    n_tests++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid: got %b want 1 (addr %03h)", rvalid, a);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(1'b1, a, d, r);
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] r);
    bus_xfer(1'b0, a, 32'h0, r);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    tx_q.delete();
    rx_q.delete();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic cpol, input logic cpha, input logic msb, input logic rx_en);
    mon_en = 1'b0;
    bus_wr(A_CFG, {12'b0, rx_en, msb, cpha, cpol, div});
    m_cpol = cpol; m_cpha = cpha; m_msb = msb;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    bit done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      bus_rd(A_ST, st);
      if (st[4] == 1'b0) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_idle_timeout: busy still 1, want 0", tag);
    end
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] r, e;
    e = (rx_q.size() != 0) ? {23'b0, 1'b1, rx_q.pop_front()} : 32'h0;
    bus_rd(A_RX, r);
    n_tests++;
    if (r !== e) begin
      n_fail++;
      $display("FAIL %s_rxdata: got %08h want %08h", tag, r, e);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    n_tests++;
    if (cs_n !== 4'hF || sck !== 1'b0 || mosi !== 1'b0 || irq !== 1'b0 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pins: cs=%h sck=%b mosi=%b irq=%b rvalid=%b want F 0 0 0 0", cs_n, sck, mosi, irq, rvalid);
    end
    bus_rd(A_ST, r);
    check_val("reset_status", r, 32'h0000000A);
    bus_rd(A_CFG, r);
    check_val("reset_config", r, 32'h000C0001);
    check_rx("reset");
  endtask

  task automatic test_mode0();
    logic [31:0] r;
    do_reset();
    set_cfg(16'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    bus_wr(A_CS, 32'hFFFF_FFF5);
    bus_rd(A_CS, r);
    check_val("cs_readback", r, 32'h5);
    check_val("cs_pins", {28'b0, cs_n}, 32'h5);
    rises = 0;
    tx_q.push_back(8'hA5);
    rx_q.push_back(8'hA5);
    bus_wr(A_TX, 32'hA5);
    wait_idle("mode0");
    check_val("mode0_sck_rises", rises, 8);
    check_val("mode0_sck_span", last_rise - first_rise, 28);
    check_val("mode0_tx_drained", tx_q.size(), 0);
    check_rx("mode0");
    check_rx("mode0_empty");
  endtask

  task automatic test_mode3();
    do_reset();
    set_cfg(16'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("mode3_sck_idle", {31'b0, sck}, 32'h1);
    tx_q.push_back(8'h01);
    rx_q.push_back(8'h01);
    bus_wr(A_TX, 32'h01);
    wait_idle("mode3");
    check_val("mode3_sck_idle_after", {31'b0, sck}, 32'h1);
    check_val("mode3_tx_drained", tx_q.size(), 0);
    check_rx("mode3");
  endtask

  task automatic test_modes();
    logic [7:0] b;
    do_reset();
    for (int m = 0; m < 4; m++) begin
      set_cfg(16'(m), m[1], m[0], (m < 2), 1'b1);
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        rx_q.push_back(b);
        bus_wr(A_TX, {24'b0, b});
      end
      wait_idle("modes");
      for (int k = 0; k < 3; k++) check_rx("modes");
    end
    check_val("modes_tx_drained", tx_q.size(), 0);
  endtask

  task automatic test_tx_ovf();
    logic [31:0] r;
    int seen0;
    logic [7:0] b;
    do_reset();
    set_cfg(16'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    seen0 = tx_seen;
    for (int i = 0; i < TxD + 2; i++) begin
      b = 8'(i + 8'h40);
      if (i < TxD + 1) tx_q.push_back(b);
      bus_wr(A_TX, {24'b0, b});
    end
    bus_rd(A_ST, r);
    check_val("txovf_status_full", r, 32'h00200039);
    wait_idle("txovf");
    check_val("txovf_bytes_sent", tx_seen - seen0, TxD + 1);
    check_val("txovf_tx_drained", tx_q.size(), 0);
    bus_rd(A_ST, r);
    check_val("txovf_status_idle", r, 32'h0000002A);
    bus_wr(A_INT, 32'h100);
    bus_rd(A_ST, r);
    check_val("txovf_cleared", r, 32'h0000000A);
  endtask

  task automatic test_rx_ovf();
    logic [31:0] r;
    logic [7:0] b;
    do_reset();
    set_cfg(16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < RxD + 2; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      if (i < RxD) rx_q.push_back(b);
      bus_wr(A_TX, {24'b0, b});
    end
    wait_idle("rxovf");
    repeat (4) @(posedge clk);
    bus_rd(A_ST, r);
    check_val("rxovf_status", r, 32'h00000046);
    for (int i = 0; i < RxD; i++) check_rx("rxovf");
    check_rx("rxovf_empty");
    bus_rd(A_ST, r);
    check_val("rxovf_status_drained", r, 32'h0000004A);
    bus_wr(A_INT, 32'h100);
    bus_rd(A_ST, r);
    check_val("rxovf_cleared", r, 32'h0000000A);
  endtask

  task automatic test_busy_irq();
    logic [31:0] r;
    bit rose = 0;
    do_reset();
    set_cfg(16'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_wr(A_INT, 32'h1);
    bus_rd(A_INT, r);
    check_val("intr_readback", r, 32'h1);
    check_val("irq_idle_high", {31'b0, irq}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tx_q.push_back(8'(8'h5A + k));
      bus_wr(A_TX, {24'b0, 8'(8'h5A + k)});
    end
    bus_wr(A_CFG, 32'h0004_0007);
    bus_rd(A_CFG, r);
    check_val("cfg_busy_ignored", r, 32'h0004_0003);
    check_val("irq_busy_low", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 5000 && !rose; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) rose = 1;
    end
    check_val("irq_rise", {31'b0, rose}, 32'h1);
    check_val("irq_tx_drained", tx_q.size(), 0);
    bus_rd(A_ST, r);
    check_val("irq_status_idle", r, 32'h0000000A);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    do_reset();
    set_cfg(16'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    mon_en = 1'b0;
    bus_wr(A_CS, 32'h0);
    bus_wr(A_TX, 32'hFF);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sck !== 1'b0 || mosi !== 1'b0 || cs_n !== 4'hF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_pins: sck=%b mosi=%b cs=%h irq=%b want 0 0 F 0", sck, mosi, cs_n, irq);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_rd(A_ST, r);
    check_val("midreset_status", r, 32'h0000000A);
    check_rx("midreset");
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    test_reset();
    test_mode0();
    test_mode3();
    test_modes();
    test_tx_ovf();
    test_rx_ovf();
    test_busy_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
